// File: rtl/partial_energy_pkg.sv
// Shared types and helpers for the time-multiplexed single-spin energy calculator.
//   state_e    : controller states (idle / accumulate / result held)
//   prod_w     : width of one signed spin*J product (one guard bit so -(-2^(BITJ-1)) is exact)
//   acc_w      : accumulator width, wide enough that no internal overflow can occur
//   msb_index  : position of the highest set bit (0 for a zero input)
//   saturate   : clip a wide signed value to an L-bit signed range and flag the clip
package partial_energy_pkg;

  typedef enum logic [1:0] {StIdle, StAcc, StDone} state_e;

  // Width used for the final sum before saturation.
  localparam int unsigned CalcW = 64;

  typedef struct packed {
    logic                    ovf;
    logic signed [CalcW-1:0] val;
  } sat_t;

  function automatic int unsigned prod_w(input int unsigned bitj);
    return bitj + 1;
  endfunction

  function automatic int unsigned acc_w(input int unsigned bitj, input int unsigned dataspin,
                                        input int unsigned scaling_bit, input int unsigned bith);
    return prod_w(bitj) + unsigned'($clog2(dataspin)) + scaling_bit + bith;
  endfunction

  function automatic logic [4:0] msb_index(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  function automatic sat_t saturate(input logic signed [CalcW-1:0] v, input int unsigned l);
    logic signed [CalcW-1:0] hi;
    logic signed [CalcW-1:0] lo;
    sat_t                    r;
    hi    = (64'sd1 <<< (l - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (l - 1));
    r.ovf = 1'b0;
    r.val = v;
    if (v > hi) begin
      r.val = hi;
      r.ovf = 1'b1;
    end else if (v < lo) begin
      r.val = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/partial_energy_seq_if.sv
// Stream bundle of partial_energy_seq: config offer, weight-chunk stream and result stream.
//   master : the side that offers config/chunks and accepts results (reader / monitor)
//   slave  : the energy calculator itself
interface partial_energy_seq_if #(
  parameter int unsigned BITJ             = 4,
  parameter int unsigned BITH             = 4,
  parameter int unsigned DATASPIN         = 256,
  parameter int unsigned PAR              = 16,
  parameter int unsigned SCALING_BIT      = 5,
  parameter int unsigned LOCAL_ENERGY_BIT = 16
);

  logic                        cfg_valid_i;
  logic                        cfg_ready_o;
  logic [DATASPIN-1:0]         spin_i;
  logic                        current_spin_i;
  logic [BITH-1:0]             hbias_i;
  logic [SCALING_BIT-1:0]      hscaling_i;
  logic                        w_valid_i;
  logic                        w_ready_o;
  logic [PAR*BITJ-1:0]         weight_i;
  logic                        energy_valid_o;
  logic                        energy_ready_i;
  logic [LOCAL_ENERGY_BIT-1:0] energy_o;
  logic                        overflow_o;

  modport master (
    output cfg_valid_i, spin_i, current_spin_i, hbias_i, hscaling_i,
    output w_valid_i, weight_i, energy_ready_i,
    input  cfg_ready_o, w_ready_o, energy_valid_o, energy_o, overflow_o
  );

  modport slave (
    input  cfg_valid_i, spin_i, current_spin_i, hbias_i, hscaling_i,
    input  w_valid_i, weight_i, energy_ready_i,
    output cfg_ready_o, w_ready_o, energy_valid_o, energy_o, overflow_o
  );

endinterface

// File: rtl/adder_tree.sv
// Signed reduction of N packed W-bit operands.
//   operands_i : N operands, operand i at bits [(i+1)*W-1 -: W]
//   sum_o      : signed sum, OW bits (default grows by clog2(N) so it cannot overflow)
module adder_tree #(
  parameter int unsigned N  = 4,
  parameter int unsigned W  = 5,
  parameter int unsigned OW = W + $clog2(N)
) (
  input  logic [N*W-1:0]      operands_i,
  output logic signed [OW-1:0] sum_o
);

  // Written as a chain; synthesis rebalances it into a tree.
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      sum_o = sum_o + OW'(signed'(operands_i[i*W +: W]));
    end
  end

endmodule

// File: rtl/chunk_mac.sv
// Combinational multiply-accumulate of one chunk: sum over j of (s_j ? J_j : -J_j).
//   weight_i : PAR signed J values, weight j at bits [(j+1)*BITJ-1 -: BITJ]
//   spin_i   : PAR spins, 1 = +1, 0 = -1
//   sum_o    : signed chunk sum
module chunk_mac import partial_energy_pkg::*; #(
  parameter int unsigned BITJ  = 4,
  parameter int unsigned PAR   = 16,
  parameter int unsigned PRODW = prod_w(BITJ),
  parameter int unsigned SUMW  = PRODW + $clog2(PAR)
) (
  input  logic [PAR*BITJ-1:0]  weight_i,
  input  logic [PAR-1:0]       spin_i,
  output logic signed [SUMW-1:0] sum_o
);

  logic [PAR*PRODW-1:0] prod;

  // Negation happens after widening, so the most negative J negates exactly.
  always_comb begin
    prod = '0;
    for (int j = 0; j < int'(PAR); j++) begin
      prod[j*PRODW +: PRODW] = spin_i[j] ?  PRODW'(signed'(weight_i[j*BITJ +: BITJ]))
                                         : -PRODW'(signed'(weight_i[j*BITJ +: BITJ]));
    end
  end

  adder_tree #(
    .N (PAR),
    .W (PRODW),
    .OW(SUMW)
  ) u_adder_tree (
    .operands_i(prod),
    .sum_o     (sum_o)
  );

endmodule

// File: rtl/partial_energy_seq.sv
// Time-multiplexed single-spin local energy: sigma_c * (sum_i s_i*J_i + h*scale).
// The J row arrives as NCHUNK chunks of PAR weights; the result is saturated to
// LOCAL_ENERGY_BIT bits and held until the consumer accepts it.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (slave)  : config offer (spins, sigma, h, hscaling), weight-chunk stream,
//                  result stream (energy_o, overflow_o)
module partial_energy_seq import partial_energy_pkg::*; #(
  parameter int unsigned BITJ             = 4,
  parameter int unsigned BITH             = 4,
  parameter int unsigned DATASPIN         = 256,
  parameter int unsigned PAR              = 16,
  parameter int unsigned SCALING_BIT      = 5,
  parameter int unsigned LOCAL_ENERGY_BIT = 16
) (
  input logic                 clk_i,
  input logic                 rst_i,
  partial_energy_seq_if.slave bus
);

  localparam int unsigned NCHUNK = DATASPIN / PAR;
  localparam int unsigned PRODW  = prod_w(BITJ);
  localparam int unsigned ACCW   = acc_w(BITJ, DATASPIN, SCALING_BIT, BITH);
  localparam int unsigned SUMW   = PRODW + $clog2(PAR);
  localparam int unsigned KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if (DATASPIN % PAR != 0) begin : g_par_check
    $error("DATASPIN must be a multiple of PAR");
  end

  state_e                      state_q, state_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [ACCW-1:0]      acc_q, acc_d;
  logic [DATASPIN-1:0]         spin_q, spin_d;
  logic                        sigma_q, sigma_d;
  logic signed [BITH-1:0]      h_q, h_d;
  logic [SCALING_BIT-1:0]      hs_q, hs_d;
  logic [LOCAL_ENERGY_BIT-1:0] energy_q, energy_d;
  logic                        ovf_q, ovf_d;

  logic [31:0]             chunk_base;
  logic [PAR-1:0]          spin_chunk;
  logic signed [SUMW-1:0]  chunk_sum;
  logic signed [CalcW-1:0] e_raw;
  logic signed [CalcW-1:0] e_signed;
  sat_t                    sat;
  logic                    last_chunk;
  logic                    unused_sat;

  assign chunk_base = 32'(k_q) * PAR;
  assign spin_chunk = PAR'(spin_q >> chunk_base);
  assign last_chunk = (k_q == KW'(NCHUNK - 1));

  chunk_mac #(
    .BITJ (BITJ),
    .PAR  (PAR),
    .PRODW(PRODW),
    .SUMW (SUMW)
  ) u_chunk_mac (
    .weight_i(bus.weight_i),
    .spin_i  (spin_chunk),
    .sum_o   (chunk_sum)
  );

  // Final value uses the last chunk directly so the result registers on the same edge.
  always_comb begin
    e_raw    = CalcW'(acc_q) + CalcW'(chunk_sum)
             + (CalcW'(h_q) <<< msb_index(32'(hs_q)));
    e_signed = sigma_q ? e_raw : -e_raw;
    sat      = saturate(e_signed, LOCAL_ENERGY_BIT);
  end

  assign unused_sat = ^sat.val[CalcW-1:LOCAL_ENERGY_BIT];

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    acc_d    = acc_q;
    spin_d   = spin_q;
    sigma_d  = sigma_q;
    h_d      = h_q;
    hs_d     = hs_q;
    energy_d = energy_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.cfg_valid_i) begin
          spin_d  = bus.spin_i;
          sigma_d = bus.current_spin_i;
          h_d     = bus.hbias_i;
          hs_d    = bus.hscaling_i;
          acc_d   = '0;
          k_d     = '0;
          state_d = StAcc;
        end
      end
      StAcc: begin
        if (bus.w_valid_i) begin
          if (last_chunk) begin
            energy_d = sat.val[LOCAL_ENERGY_BIT-1:0];
            ovf_d    = sat.ovf;
            acc_d    = '0;
            k_d      = '0;
            state_d  = StDone;
          end else begin
            acc_d = acc_q + ACCW'(chunk_sum);
            k_d   = k_q + KW'(1);
          end
        end
      end
      StDone: begin
        if (bus.energy_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      k_q      <= '0;
      acc_q    <= '0;
      spin_q   <= '0;
      sigma_q  <= 1'b0;
      h_q      <= '0;
      hs_q     <= '0;
      energy_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      spin_q   <= spin_d;
      sigma_q  <= sigma_d;
      h_q      <= h_d;
      hs_q     <= hs_d;
      energy_q <= energy_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.cfg_ready_o    = (state_q == StIdle);
  assign bus.w_ready_o      = (state_q == StAcc);
  assign bus.energy_valid_o = (state_q == StDone);
  assign bus.energy_o       = energy_q;
  assign bus.overflow_o     = ovf_q;

endmodule
